uart_rx_sampler: RTL and testbench

- Timing front end of the UART receiver. Sits directly upstream of the RX control FSM.
- Runs the oversampling edge counter and the frame bit counter.
- Takes three mid-bit samples of the serial line and majority-votes them.
- Emits a one-cycle `sampled` strobe, the voted bit, and `bit_count`. The FSM, the start/parity/stop checkers and the deserializer consume these.

---
 rtl/uart_rx_pkg.sv | 31 +++
 rtl/uart_rx_sampler_if.sv | 29 ++
 rtl/uart_rx_edge_bit_counter.sv | 52 +++++
 rtl/uart_rx_sampler.sv | 90 +++++++++
 tb/tb_uart_rx_sampler.sv | 186 ++++++++++++++++++
 5 files changed

// File: rtl/uart_rx_pkg.sv
// rtl/uart_rx_pkg.sv - shared widths, legal prescales and helpers for the UART receiver
//
// Purpose: common constants and small functions used by the RX sampler slice.
// Contents: PRESCALE_W, BITCNT_W, PRESC_8/16/32, FRAME_BITS_NO_PARITY/PARITY,
//           legal_prescale() and majority3().
package uart_rx_pkg;

  localparam int PRESCALE_W = 6;
  localparam int BITCNT_W   = 4;

  localparam logic [PRESCALE_W-1:0] PRESC_8  = 6'd8;
  localparam logic [PRESCALE_W-1:0] PRESC_16 = 6'd16;
  localparam logic [PRESCALE_W-1:0] PRESC_32 = 6'd32;

  localparam int FRAME_BITS_NO_PARITY = 10;
  localparam int FRAME_BITS_PARITY    = 11;

  // Anything other than 16 or 32 runs at 8x oversampling.
  function automatic logic [PRESCALE_W-1:0] legal_prescale(input logic [PRESCALE_W-1:0] p);
    case (p)
      PRESC_16: return PRESC_16;
      PRESC_32: return PRESC_32;
      default:  return PRESC_8;
    endcase
  endfunction

  function automatic logic majority3(input logic [2:0] s);
    return (s[0] & s[1]) | (s[0] & s[2]) | (s[1] & s[2]);
  endfunction

endpackage

// File: rtl/uart_rx_sampler_if.sv
// rtl/uart_rx_sampler_if.sv - signal bundle between RX control FSM and sampler
//
// Purpose: groups the sampler's line, control and result signals.
// Signals: S_Data (serial line), Prescale, count_EN, S_EN  (FSM/pin -> sampler)
//          edge_count, bit_count, sampled, sampled_bit     (sampler -> FSM)
// Modports: master = FSM side, slave = sampler side.
interface uart_rx_sampler_if;
  import uart_rx_pkg::*;

  logic                  S_Data;
  logic [PRESCALE_W-1:0] Prescale;
  logic                  count_EN;
  logic                  S_EN;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BITCNT_W-1:0]   bit_count;
  logic                  sampled;
  logic                  sampled_bit;

  modport master (
    output S_Data, Prescale, count_EN, S_EN,
    input  edge_count, bit_count, sampled, sampled_bit
  );

  modport slave (
    input  S_Data, Prescale, count_EN, S_EN,
    output edge_count, bit_count, sampled, sampled_bit
  );

endinterface

// File: rtl/uart_rx_edge_bit_counter.sv
// rtl/uart_rx_edge_bit_counter.sv - prescale latch plus oversampling edge and bit counters
//
// Purpose: tracks position within a bit (edge_count) and completed bit periods (bit_count).
// Ports: CLK, Reset (async, active-high), count_EN (enable; low clears counters),
//        Prescale (raw ratio), prescale_eff (ratio in force this cycle),
//        edge_count (0..P-1), bit_count.
module uart_rx_edge_bit_counter
  import uart_rx_pkg::*;
(
  input  logic                  CLK,
  input  logic                  Reset,
  input  logic                  count_EN,
  input  logic [PRESCALE_W-1:0] Prescale,
  output logic [PRESCALE_W-1:0] prescale_eff,
  output logic [PRESCALE_W-1:0] edge_count,
  output logic [BITCNT_W-1:0]   bit_count
);

  logic                  count_en_q;
  logic [PRESCALE_W-1:0] prescale_q;
  logic                  frame_start;
  logic                  bit_end;

  // On the first enabled cycle the latch is still being written, so use the
  // incoming (legalised) value directly; afterwards the frame-long copy.
  assign frame_start  = count_EN & ~count_en_q;
  assign prescale_eff = frame_start ? legal_prescale(Prescale) : prescale_q;
  assign bit_end      = (edge_count == prescale_eff - 6'd1);

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      count_en_q <= 1'b0;
      prescale_q <= PRESC_8;
      edge_count <= '0;
      bit_count  <= '0;
    end else begin
      count_en_q <= count_EN;
      if (frame_start)
        prescale_q <= legal_prescale(Prescale);
      if (!count_EN) begin
        edge_count <= '0;
        bit_count  <= '0;
      end else if (bit_end) begin
        edge_count <= '0;
        bit_count  <= bit_count + 1'b1;
      end else begin
        edge_count <= edge_count + 1'b1;
      end
    end
  end

endmodule

// File: rtl/uart_rx_sampler.sv
// rtl/uart_rx_sampler.sv - UART RX timing front end: counters, 3-point mid-bit capture, majority vote
//
// Purpose: captures S_Data at edge_count P/2-1, P/2, P/2+1 and emits the voted bit with a
//          one-cycle `sampled` strobe in the following cycle.
// Ports: CLK, Reset (async, active-high), rx (uart_rx_sampler_if.slave).
// Option: RX_SYNC_EN - when defined, S_Data goes through a 2-flop synchronizer (reset 1).
module uart_rx_sampler
  import uart_rx_pkg::*;
(
  input logic             CLK,
  input logic             Reset,
  uart_rx_sampler_if.slave rx
);

  logic                  din;
  logic [PRESCALE_W-1:0] prescale_eff;
  logic [PRESCALE_W-1:0] edge_count;
  logic [BITCNT_W-1:0]   bit_count;
  logic [PRESCALE_W-1:0] mid;
  logic                  at_s0, at_s1, at_s2;
  logic [2:0]            votes;
  logic [1:0]            stage;
  logic                  sampled_q;
  logic                  sampled_bit_q;

`ifdef RX_SYNC_EN
  logic [1:0] sync_q;

  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) sync_q <= 2'b11;
    else       sync_q <= {sync_q[0], rx.S_Data};
  end

  assign din = sync_q[1];
`else
  assign din = rx.S_Data;
`endif

  uart_rx_edge_bit_counter u_counter (
    .CLK          (CLK),
    .Reset        (Reset),
    .count_EN     (rx.count_EN),
    .Prescale     (rx.Prescale),
    .prescale_eff (prescale_eff),
    .edge_count   (edge_count),
    .bit_count    (bit_count)
  );

  assign mid   = prescale_eff >> 1;
  assign at_s0 = (edge_count == mid - 6'd1);
  assign at_s1 = (edge_count == mid);
  assign at_s2 = (edge_count == mid + 6'd1);

  // stage counts consecutive enabled captures within the current bit; the vote
  // is only issued when all three happened, so an S_EN gap suppresses the strobe.
  // The third sample is voted straight from din so the strobe lands one cycle
  // after the last capture.
  always_ff @(posedge CLK or posedge Reset) begin
    if (Reset) begin
      votes         <= 3'b111;
      stage         <= 2'd0;
      sampled_q     <= 1'b0;
      sampled_bit_q <= 1'b1;
    end else begin
      sampled_q <= 1'b0;
      if (!rx.S_EN) begin
        stage <= 2'd0;
      end else if (at_s0) begin
        votes[0] <= din;
        stage    <= 2'd1;
      end else if (at_s1) begin
        votes[1] <= din;
        stage    <= (stage == 2'd1) ? 2'd2 : 2'd0;
      end else if (at_s2) begin
        votes[2] <= din;
        stage    <= 2'd0;
        if (stage == 2'd2) begin
          sampled_q     <= 1'b1;
          sampled_bit_q <= majority3({din, votes[1], votes[0]});
        end
      end
    end
  end

  assign rx.edge_count  = edge_count;
  assign rx.bit_count   = bit_count;
  assign rx.sampled     = sampled_q;
  assign rx.sampled_bit = sampled_bit_q;

endmodule

// File: tb/tb_uart_rx_sampler.sv
// tb/tb_uart_rx_sampler.sv - directed self-checking bench for uart_rx_sampler
module tb_uart_rx_sampler;
  import uart_rx_pkg::*;

`ifdef RX_SYNC_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 0;
`endif

  logic CLK;
  logic Reset;
  int   total;
  int   bad;

  uart_rx_sampler_if rx_if ();

  uart_rx_sampler dut (
    .CLK   (CLK),
    .Reset (Reset),
    .rx    (rx_if)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One bit period of p cycles starting at edge_count 0. v0..v2 are the values
  // that must reach the three capture points, dflt fills the rest, gl forces a
  // raw low pin at that edge (-1 for none). base is bit_count during the bit.
  task automatic run_bit(input int p, input logic v0, input logic v1, input logic v2,
                         input logic dflt, input int gl, input logic exp,
                         input int base, input string tag);
    int   strobes;
    int   idx;
    int   en;
    logic d;
    strobes = 0;
    for (int ec = 0; ec < p; ec++) begin
      idx = ec + LAT;
      d   = dflt;
      if (idx == p/2 - 1) d = v0;
      if (idx == p/2)     d = v1;
      if (idx == p/2 + 1) d = v2;
      if (ec == gl)       d = 1'b0;
      rx_if.S_Data = d;
      step();
      en = (ec + 1) % p;
      chk($sformatf("%s_edge%0d", tag, ec + 1), rx_if.edge_count, en);
      chk($sformatf("%s_bitcnt%0d", tag, ec + 1), rx_if.bit_count, (en == 0) ? base + 1 : base);
      chk($sformatf("%s_strobe%0d", tag, ec + 1), rx_if.sampled, (en == p/2 + 2) ? 1 : 0);
      if (rx_if.sampled) strobes++;
      if (en == p/2 + 2) chk($sformatf("%s_bit", tag), rx_if.sampled_bit, exp);
    end
    chk($sformatf("%s_nstrobes", tag), strobes, 1);
  endtask

  task automatic clear_counters(input string tag);
    rx_if.count_EN = 1'b0;
    step();
    chk($sformatf("%s_clr_edge", tag), rx_if.edge_count, 0);
    chk($sformatf("%s_clr_bit", tag), rx_if.bit_count, 0);
  endtask

  initial begin
    logic [9:0] frame;
    total = 0;
    bad   = 0;

    Reset          = 1'b1;
    rx_if.S_Data   = 1'b1;
    rx_if.Prescale = PRESC_8;
    rx_if.count_EN = 1'b0;
    rx_if.S_EN     = 1'b0;
    step();
    step();
    Reset = 1'b0;
    step();
    chk("rst_edge", rx_if.edge_count, 0);
    chk("rst_bit", rx_if.bit_count, 0);
    chk("rst_sampled", rx_if.sampled, 0);
    chk("rst_sbit", rx_if.sampled_bit, 1);

    // P=8, line low for one bit: one strobe at edge 6, bit_count 1 at the wrap
    rx_if.Prescale = PRESC_8;
    rx_if.count_EN = 1'b1;
    rx_if.S_EN     = 1'b1;
    run_bit(8, 0, 0, 0, 0, -1, 0, 0, "p8");
    clear_counters("p8");

    // P=16, split votes 0,1,0 -> 0 then 1,0,1 -> 1
    rx_if.Prescale = PRESC_16;
    rx_if.count_EN = 1'b1;
    run_bit(16, 0, 1, 0, 1, -1, 0, 0, "p16a");
    run_bit(16, 1, 0, 1, 0, -1, 1, 1, "p16b");
    chk("p16_bitcnt2", rx_if.bit_count, 2);
    clear_counters("p16");

    // P=32, frame 0x55 without parity: start 0, data LSB first, stop 1
    frame = {1'b1, 8'h55, 1'b0};
    rx_if.Prescale = PRESC_32;
    rx_if.count_EN = 1'b1;
    for (int b = 0; b < FRAME_BITS_NO_PARITY; b++)
      run_bit(32, frame[b], frame[b], frame[b], frame[b], -1, frame[b], b, $sformatf("f55_b%0d", b));
    chk("f55_bitcnt", rx_if.bit_count, 10);
    clear_counters("f55");

    // Prescale change mid-frame is ignored until count_EN restarts
    rx_if.Prescale = PRESC_16;
    rx_if.count_EN = 1'b1;
    for (int b = 0; b < 3; b++)
      run_bit(16, 1, 1, 1, 1, -1, 1, b, $sformatf("chg16_b%0d", b));
    rx_if.Prescale = PRESC_8;
    run_bit(16, 0, 0, 0, 0, -1, 0, 3, "chg16_b3");
    clear_counters("chg");
    rx_if.count_EN = 1'b1;
    run_bit(8, 1, 1, 1, 1, -1, 1, 0, "chg8_b0");
    run_bit(8, 0, 0, 0, 0, -1, 0, 1, "chg8_b1");
    clear_counters("chg8");

    // Illegal prescale 12 runs as 8
    rx_if.Prescale = 6'd12;
    rx_if.count_EN = 1'b1;
    run_bit(8, 1, 1, 1, 1, -1, 1, 0, "p12");

    // S_EN gap at the middle capture suppresses that bit's strobe
    rx_if.S_Data = 1'b0;
    for (int ec = 0; ec < 8; ec++) begin
      rx_if.S_EN = (ec == 4) ? 1'b0 : 1'b1;
      step();
      chk($sformatf("sen_gap_strobe%0d", ec + 1), rx_if.sampled, 0);
    end
    rx_if.S_EN = 1'b1;
    chk("sen_gap_hold", rx_if.sampled_bit, 1);
    chk("sen_gap_bitcnt", rx_if.bit_count, 2);
    clear_counters("sen");

    // Reset at edge 5 of bit 4
    rx_if.Prescale = PRESC_8;
    rx_if.count_EN = 1'b1;
    for (int b = 0; b < 4; b++)
      run_bit(8, 0, 0, 0, 0, -1, 0, b, $sformatf("mrst_b%0d", b));
    rx_if.S_Data = 1'b0;
    for (int i = 0; i < 5; i++) step();
    chk("mrst_pre_edge", rx_if.edge_count, 5);
    chk("mrst_pre_bit", rx_if.bit_count, 4);
    Reset = 1'b1;
    #1;
    chk("mrst_edge", rx_if.edge_count, 0);
    chk("mrst_bit", rx_if.bit_count, 0);
    chk("mrst_sampled", rx_if.sampled, 0);
    chk("mrst_sbit", rx_if.sampled_bit, 1);
    rx_if.count_EN = 1'b0;
    rx_if.S_EN     = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("mrst_nostrobe%0d", i), rx_if.sampled, 0);
      chk($sformatf("mrst_edge_hold%0d", i), rx_if.edge_count, 0);
    end
    Reset = 1'b0;
    step();

    // Single-cycle low glitch at edge 4 is outvoted
    rx_if.count_EN = 1'b1;
    rx_if.S_EN     = 1'b1;
    run_bit(8, 0, 0, 0, 0, -1, 0, 0, "gl_b0");
    run_bit(8, 1, 1, 1, 1, 4, 1, 1, "gl_b1");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
